// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Stall/flush side of the xgriscv hazard logic. It covers the cases that
// forwarding cannot: load-use, pending MDU writes (RAW and WAW), the single
// MDU being occupied, data-memory wait states and taken-branch redirects.
// It also keeps a one-entry MDU scoreboard, a saturating count of fetch-stall
// cycles and a sticky flag for an MDU that stays busy too long.
module hazard_stall_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MDU_TIMEOUT = 64,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [RFIDX_WIDTH-1:0] rs1D,
  input  logic [RFIDX_WIDTH-1:0] rs2D,
  input  logic [RFIDX_WIDTH-1:0] rdD,
  input  logic                   regwriteD,
  input  logic                   mdu_startD,
  input  logic [RFIDX_WIDTH-1:0] rdE,
  input  logic                   regwriteE,
  input  logic                   memreadE,
  input  logic                   mdu_startE,
  input  logic                   branch_takenE,
  input  logic                   dmem_reqM,
  input  logic                   dmem_ready,
  input  logic                   mdu_done,
  output logic                   stallF,
  output logic                   stallD,
  output logic                   stallE,
  output logic                   stallM,
  output logic                   flushD,
  output logic                   flushE,
  output logic                   flushW,
  output logic                   mdu_busy,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic                   mdu_timeout
);

  // The busy counter only has to reach MDU_TIMEOUT, then it parks there.
  localparam int            BW       = $clog2(MDU_TIMEOUT + 1);
  localparam logic [BW-1:0] BUSY_MAX = BW'(MDU_TIMEOUT);
  localparam logic [BW-1:0] BUSY_ONE = BW'(1);

  logic [RFIDX_WIDTH-1:0] pend_rd;
  logic [BW-1:0]          busy_cnt;
  logic                   memw;
  logic                   lu;
  logic                   sb;
  logic                   st;
  logic                   accept;

  // Hazard conditions. mdu_done is folded into sb/st so that a result that is
  // written back this cycle releases the dependent D instruction at once
  // (the register file is write-through).
  assign memw = dmem_reqM & ~dmem_ready;
  assign lu   = memreadE & regwriteE & (rdE != '0) & ((rdE == rs1D) | (rdE == rs2D));
  assign sb   = mdu_busy & ~mdu_done & (pend_rd != '0) &
                ((pend_rd == rs1D) | (pend_rd == rs2D) | (regwriteD & (pend_rd == rdD)));
  assign st   = mdu_startD & ((mdu_busy & ~mdu_done) | mdu_startE);

  // An MDU op in E is only handed over when E actually advances.
  assign accept = mdu_startE & ~stallE;

  // Prioritised stall/flush decode: a memory wait freezes everything (and holds
  // any branch in E until the access finishes), a redirect beats data hazards
  // because the D instruction is wrong-path anyway, otherwise data hazards
  // insert a bubble into E.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushW = 1'b0;
    if (memw) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (branch_takenE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (lu | sb | st) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  // One-entry MDU scoreboard with busy-age tracking. A new accept wins over a
  // simultaneous completion; the timeout flag is sticky until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mdu_busy    <= 1'b0;
      pend_rd     <= '0;
      busy_cnt    <= '0;
      mdu_timeout <= 1'b0;
    end else if (accept) begin
      mdu_busy <= 1'b1;
      pend_rd  <= rdE;
      busy_cnt <= '0;
    end else if (mdu_busy) begin
      if (busy_cnt != BUSY_MAX) begin
        busy_cnt <= busy_cnt + BUSY_ONE;
      end
      if (busy_cnt == BUSY_MAX - BUSY_ONE) begin
        mdu_timeout <= 1'b1;
      end
      if (mdu_done) begin
        mdu_busy <= 1'b0;
      end
    end
  end

  // Saturating count of cycles in which fetch was held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
    end else if (stallF && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
// Directed stimulus for the hazard/stall controller. A behavioural model of
// the pipeline-control rules runs alongside; its outputs are compared with the
// DUT on every falling edge while out of reset, and a set of literal
// expectations at key points pins the model itself.
module tb_hazard_stall_ctrl;

  localparam int MDU_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [4:0] rs1D, rs2D, rdD, rdE;
  logic       regwriteD, mdu_startD, regwriteE, memreadE, mdu_startE;
  logic       branch_takenE, dmem_reqM, dmem_ready, mdu_done;
  logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW;
  logic       mdu_busy, mdu_timeout;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  hazard_stall_ctrl #(.CNT_W(16), .MDU_TIMEOUT(MDU_TIMEOUT), .RFIDX_WIDTH(5)) dut (
    .clk(clk), .rstn(rstn),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .regwriteD(regwriteD), .mdu_startD(mdu_startD),
    .rdE(rdE), .regwriteE(regwriteE), .memreadE(memreadE), .mdu_startE(mdu_startE),
    .branch_takenE(branch_takenE), .dmem_reqM(dmem_reqM), .dmem_ready(dmem_ready),
    .mdu_done(mdu_done),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushW(flushW),
    .mdu_busy(mdu_busy), .stall_cycles(stall_cycles), .mdu_timeout(mdu_timeout)
  );

  always #5 clk = ~clk;

  // Model state: who owns the MDU, since which cycle, and totals.
  int         m_cyc = 0;
  int         m_since = 0;
  int         m_stalls = 0;
  logic       m_busy = 1'b0;
  logic [4:0] m_pend = '0;
  logic       m_timeout = 1'b0;

  // Expected controls, derived from a single "what must the pipe do" choice.
  int   action;
  logic e_stallF, e_stallD, e_stallE, e_stallM, e_flushD, e_flushE, e_flushW;

  always_comb begin
    logic data_hazard;
    data_hazard = 1'b0;
    if (memreadE && regwriteE && rdE != 0 && (rdE == rs1D || rdE == rs2D))
      data_hazard = 1'b1;
    if (m_busy && !mdu_done && m_pend != 0 &&
        (m_pend == rs1D || m_pend == rs2D || (regwriteD && m_pend == rdD)))
      data_hazard = 1'b1;
    if (mdu_startD && ((m_busy && !mdu_done) || mdu_startE))
      data_hazard = 1'b1;
    action = 0;
    if (dmem_reqM && !dmem_ready) action = 1;
    else if (branch_takenE)       action = 2;
    else if (data_hazard)         action = 3;
    e_stallF = (action == 1) || (action == 3);
    e_stallD = e_stallF;
    e_stallE = (action == 1);
    e_stallM = (action == 1);
    e_flushW = (action == 1);
    e_flushD = (action == 2);
    e_flushE = (action == 2) || (action == 3);
  end

  // Model bookkeeping at each clock edge.
  always @(posedge clk or negedge rstn) begin
    logic was_stallF, took;
    if (!rstn) begin
      m_busy = 1'b0; m_pend = '0; m_since = 0; m_timeout = 1'b0; m_stalls = 0;
    end else begin
      was_stallF = e_stallF;
      took = mdu_startE && !e_stallE;
      m_cyc = m_cyc + 1;
      if (was_stallF && m_stalls < 65535) m_stalls = m_stalls + 1;
      if (took) begin
        m_busy = 1'b1; m_pend = rdE; m_since = m_cyc;
      end else if (m_busy) begin
        if (m_cyc - m_since >= MDU_TIMEOUT) m_timeout = 1'b1;
        if (mdu_done) m_busy = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearInputs;
    rs1D = 0; rs2D = 0; rdD = 0; regwriteD = 0; mdu_startD = 0;
    rdE = 0; regwriteE = 0; memreadE = 0; mdu_startE = 0;
    branch_takenE = 0; dmem_reqM = 0; dmem_ready = 0; mdu_done = 0;
  endtask

  // Let the current inputs be taken by n rising edges; return just after.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clearInputs();
    #1 rstn = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rstn) begin
          checkOutput("stallF", 32'(stallF), 32'(e_stallF));
          checkOutput("stallD", 32'(stallD), 32'(e_stallD));
          checkOutput("stallE", 32'(stallE), 32'(e_stallE));
          checkOutput("stallM", 32'(stallM), 32'(e_stallM));
          checkOutput("flushD", 32'(flushD), 32'(e_flushD));
          checkOutput("flushE", 32'(flushE), 32'(e_flushE));
          checkOutput("flushW", 32'(flushW), 32'(e_flushW));
          checkOutput("mdu_busy", 32'(mdu_busy), 32'(m_busy));
          checkOutput("mdu_timeout", 32'(mdu_timeout), 32'(m_timeout));
          checkOutput("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        end
      end
    join_none

    // Reset state
    @(negedge clk);
    checkOutput("rst_stallF", 32'(stallF), 0);
    checkOutput("rst_busy", 32'(mdu_busy), 0);
    checkOutput("rst_cycles", 32'(stall_cycles), 0);
    checkOutput("rst_timeout", 32'(mdu_timeout), 0);
    applyStimulus(1);
    rstn = 1'b1;
    applyStimulus(1);

    // Load-use
    $display("[TB] load-use");
    memreadE = 1; regwriteE = 1; rdE = 5; rs1D = 5;
    @(negedge clk);
    checkOutput("lu_stallF", 32'(stallF), 1);
    checkOutput("lu_flushE", 32'(flushE), 1);
    checkOutput("lu_stallE", 32'(stallE), 0);
    applyStimulus(1);
    rdE = 0; rs1D = 0;
    @(negedge clk);
    checkOutput("lu_cycles", 32'(stall_cycles), 1);
    checkOutput("lu_x0_stallF", 32'(stallF), 0);
    applyStimulus(1);
    clearInputs();

    // MDU RAW
    $display("[TB] mdu raw");
    mdu_startE = 1; regwriteE = 1; rdE = 7;
    applyStimulus(1);
    clearInputs(); rs2D = 7;
    @(negedge clk);
    checkOutput("raw_busy", 32'(mdu_busy), 1);
    checkOutput("raw_stallF", 32'(stallF), 1);
    applyStimulus(2);
    mdu_done = 1;
    @(negedge clk);
    checkOutput("raw_done_stallF", 32'(stallF), 0);
    applyStimulus(1);
    clearInputs();
    @(negedge clk);
    checkOutput("raw_busy_clr", 32'(mdu_busy), 0);
    checkOutput("raw_cycles", 32'(stall_cycles), 3);
    applyStimulus(1);

    // MDU WAW, structural, done+accept
    $display("[TB] mdu waw/structural");
    mdu_startE = 1; regwriteE = 1; rdE = 3;
    applyStimulus(1);
    clearInputs(); regwriteD = 1; rdD = 3;
    @(negedge clk);
    checkOutput("waw_stallF", 32'(stallF), 1);
    applyStimulus(1);
    clearInputs(); mdu_startD = 1;
    @(negedge clk);
    checkOutput("struct_stallF", 32'(stallF), 1);
    applyStimulus(1);
    clearInputs(); mdu_done = 1; mdu_startE = 1; regwriteE = 1; rdE = 4;
    @(negedge clk);
    checkOutput("da_stallF", 32'(stallF), 0);
    applyStimulus(1);
    clearInputs(); rs1D = 4;
    @(negedge clk);
    checkOutput("da_busy", 32'(mdu_busy), 1);
    checkOutput("da_newpend_stallF", 32'(stallF), 1);
    applyStimulus(1);
    mdu_done = 1;
    @(negedge clk);
    checkOutput("da_release", 32'(stallF), 0);
    applyStimulus(1);
    clearInputs();
    @(negedge clk);
    checkOutput("waw_cycles", 32'(stall_cycles), 6);
    applyStimulus(1);

    // Memory wait vs branch, MDU handoff blocked while E is held
    $display("[TB] mem wait vs branch");
    dmem_reqM = 1; branch_takenE = 1; mdu_startE = 1; regwriteE = 1; rdE = 2;
    @(negedge clk);
    checkOutput("mw_stallM", 32'(stallM), 1);
    checkOutput("mw_flushW", 32'(flushW), 1);
    checkOutput("mw_flushD", 32'(flushD), 0);
    applyStimulus(1);
    @(negedge clk);
    checkOutput("mw_no_accept", 32'(mdu_busy), 0);
    applyStimulus(2);
    dmem_ready = 1;
    @(negedge clk);
    checkOutput("rdy_flushD", 32'(flushD), 1);
    checkOutput("rdy_flushE", 32'(flushE), 1);
    checkOutput("rdy_stallF", 32'(stallF), 0);
    applyStimulus(1);
    clearInputs(); mdu_done = 1;
    @(negedge clk);
    checkOutput("rdy_accept", 32'(mdu_busy), 1);
    checkOutput("mw_cycles", 32'(stall_cycles), 9);
    applyStimulus(1);
    clearInputs();

    // Branch beats load-use
    $display("[TB] branch vs load-use");
    branch_takenE = 1; memreadE = 1; regwriteE = 1; rdE = 6; rs1D = 6;
    @(negedge clk);
    checkOutput("br_flushD", 32'(flushD), 1);
    checkOutput("br_flushE", 32'(flushE), 1);
    checkOutput("br_stallF", 32'(stallF), 0);
    applyStimulus(1);
    clearInputs();

    // Timeout
    $display("[TB] mdu timeout");
    mdu_startE = 1; regwriteE = 1; rdE = 9;
    applyStimulus(1);
    clearInputs();
    applyStimulus(MDU_TIMEOUT - 1);
    @(negedge clk);
    checkOutput("to_before", 32'(mdu_timeout), 0);
    applyStimulus(1);
    @(negedge clk);
    checkOutput("to_raised", 32'(mdu_timeout), 1);
    mdu_done = 1;
    applyStimulus(1);
    clearInputs();
    @(negedge clk);
    checkOutput("to_sticky", 32'(mdu_timeout), 1);
    checkOutput("to_busy_clr", 32'(mdu_busy), 0);
    applyStimulus(1);

    // Reset in the middle of an MDU RAW stall
    $display("[TB] reset mid-stall");
    mdu_startE = 1; regwriteE = 1; rdE = 11;
    applyStimulus(1);
    clearInputs(); rs1D = 11;
    @(negedge clk);
    checkOutput("mid_stallF", 32'(stallF), 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rst_mid_stallF", 32'(stallF), 0);
    checkOutput("rst_mid_flushE", 32'(flushE), 0);
    checkOutput("rst_mid_busy", 32'(mdu_busy), 0);
    checkOutput("rst_mid_cycles", 32'(stall_cycles), 0);
    checkOutput("rst_mid_timeout", 32'(mdu_timeout), 0);
    applyStimulus(1);
    rstn = 1'b1;
    clearInputs();
    applyStimulus(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
